cordic_vec_seq: RTL and testbench

- Iterative CORDIC vectoring-mode engine: one shared micro-rotation datapath, reused over ITERATIONS cycles under a small FSM.
- Sits beside the unrolled pipeline as the area-optimised alternative. Accepts one (x, y) sample per transaction and returns magnitude (gain-scaled x), residual y and angle z.
- Owns the iteration counter, the atan constant selection, quadrant pre-rotation and the in/out valid-ready handshakes.

---
 rtl/cordic_vec_seq_pkg.sv | 37 +++
 rtl/cordic_vec_seq_if.sv | 31 +++
 rtl/cordic_vec_seq_step.sv | 47 ++++
 rtl/cordic_vec_seq.sv | 120 ++++++++++++
 tb/tb_cordic_vec_seq.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_vec_seq_pkg.sv
// cordic_vec_seq_pkg
//   Shared definitions for the iterative CORDIC vectoring engine:
//   data widths, iteration count, the pi/2 phase constant, the
//   arctangent table, and the FSM state encoding.
//   Phase units: 2^(PHASE_WIDTH-1) represents pi.
package cordic_vec_seq_pkg;

  localparam int WORD_WIDTH         = 16;
  localparam int PHASE_WIDTH        = 16;
  localparam int ITERATION_WIDTH    = 4;
  localparam int DEFAULT_ITERATIONS = 12;

  typedef logic signed [WORD_WIDTH-1:0]  word_t;
  typedef logic signed [PHASE_WIDTH-1:0] phase_t;
  typedef logic [ITERATION_WIDTH-1:0]    iter_t;

  localparam phase_t PHASE_HALF_PI = phase_t'(1) <<< (PHASE_WIDTH - 2);

  // round(atan(2^-i) * 2^(PHASE_WIDTH-1) / pi), i = 0..15
  localparam phase_t ATAN_TABLE [16] = '{
    16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297,
    16'sd651,  16'sd326,  16'sd163,  16'sd81,
    16'sd41,   16'sd20,   16'sd10,   16'sd5,
    16'sd3,    16'sd1,    16'sd1,    16'sd0
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic phase_t atan_lookup(input iter_t idx);
    return ATAN_TABLE[idx];
  endfunction

endpackage

// File: rtl/cordic_vec_seq_if.sv
// cordic_vec_seq_if
//   Sample-in / result-out handshake bundle for cordic_vec_seq.
//   master: the producer/consumer side (drives samples, accepts results)
//   slave : the engine side
//   Signals: in_valid/in_ready/x_in/y_in, out_valid/out_ready/x_out/
//            y_out/z_out, busy
interface cordic_vec_seq_if;
  import cordic_vec_seq_pkg::*;

  logic   in_valid;
  logic   in_ready;
  word_t  x_in;
  word_t  y_in;
  logic   out_valid;
  logic   out_ready;
  word_t  x_out;
  word_t  y_out;
  phase_t z_out;
  logic   busy;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out, busy
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out, busy
  );

endinterface

// File: rtl/cordic_vec_seq_step.sv
// cordic_vec_step
//   One combinational CORDIC vectoring micro-rotation.
//   Ports: x_cur/y_cur/z_cur  current vector and angle
//          shift             micro-rotation index (shift amount)
//          atan              arctangent constant for this index
//          x_nxt/y_nxt/z_nxt rotated vector and accumulated angle
//   Drives y toward zero; y == 0 leaves everything unchanged.
module cordic_vec_step
  import cordic_vec_seq_pkg::*;
(
  input  word_t  x_cur,
  input  word_t  y_cur,
  input  phase_t z_cur,
  input  iter_t  shift,
  input  phase_t atan,
  output word_t  x_nxt,
  output word_t  y_nxt,
  output phase_t z_nxt
);

  word_t x_sh;
  word_t y_sh;
  logic  y_pos;
  logic  y_neg;

  assign x_sh  = x_cur >>> shift;
  assign y_sh  = y_cur >>> shift;
  assign y_neg = y_cur[WORD_WIDTH-1];
  assign y_pos = !y_neg && (y_cur != '0);

  // Both updates use the pre-step x and y; sums wrap at word width.
  always_comb begin
    x_nxt = x_cur;
    y_nxt = y_cur;
    z_nxt = z_cur;
    if (y_pos) begin
      x_nxt = x_cur + y_sh;
      y_nxt = y_cur - x_sh;
      z_nxt = z_cur + atan;
    end else if (y_neg) begin
      x_nxt = x_cur - y_sh;
      y_nxt = y_cur + x_sh;
      z_nxt = z_cur - atan;
    end
  end

endmodule

// File: rtl/cordic_vec_seq.sv
// cordic_vec_seq
//   Iterative CORDIC vectoring engine: one shared micro-rotation reused
//   for ITERATIONS cycles per sample. Returns gain-scaled magnitude
//   (x_out), residual (y_out) and angle (z_out).
//   Ports: clk, rst (synchronous, active-high),
//          bus (cordic_vec_seq_if.slave): sample in, result out, busy.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   IDLE    | in_ready=1, waiting for a sample
//   ROTATE  | one micro-rotation per cycle, counter 0..ITERATIONS-1
//   DONE    | out_valid=1, result held until out_ready
module cordic_vec_seq
  import cordic_vec_seq_pkg::*;
#(
  parameter int ITERATIONS = DEFAULT_ITERATIONS
) (
  input  logic                   clk,
  input  logic                   rst,
  cordic_vec_seq_if.slave        bus
);

  localparam iter_t ITER_LAST = iter_t'(ITERATIONS - 1);

  state_t state;
  iter_t  iter;
  word_t  x_r;
  word_t  y_r;
  phase_t z_r;
  logic   in_ready_r;
  logic   out_valid_r;
  logic   busy_r;

  word_t  x_nxt;
  word_t  y_nxt;
  phase_t z_nxt;

  cordic_vec_step u_step (
    .x_cur (x_r),
    .y_cur (y_r),
    .z_cur (z_r),
    .shift (iter),
    .atan  (atan_lookup(iter)),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt),
    .z_nxt (z_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      iter        <= '0;
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            // Fold left half-plane into the right half so the
            // micro-rotations only need to cover +/- pi/2.
            if (!bus.x_in[WORD_WIDTH-1]) begin
              x_r <= bus.x_in;
              y_r <= bus.y_in;
              z_r <= '0;
            end else if (!bus.y_in[WORD_WIDTH-1]) begin
              x_r <= bus.y_in;
              y_r <= -bus.x_in;
              z_r <= PHASE_HALF_PI;
            end else begin
              x_r <= -bus.y_in;
              y_r <= bus.x_in;
              z_r <= -PHASE_HALF_PI;
            end
            iter       <= '0;
            state      <= ST_ROTATE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        ST_ROTATE: begin
          x_r <= x_nxt;
          y_r <= y_nxt;
          z_r <= z_nxt;
          if (iter == ITER_LAST) begin
            state       <= ST_DONE;
            out_valid_r <= 1'b1;
          end else begin
            iter <= iter + 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state       <= ST_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.x_out     = x_r;
  assign bus.y_out     = y_r;
  assign bus.z_out     = z_r;

endmodule

// File: tb/tb_cordic_vec_seq.sv
// tb_cordic_vec_seq
//   Directed and random stimulus for cordic_vec_seq with a scoreboard
//   of expected results pushed at each accept and popped at each
//   output handshake.
module tb_cordic_vec_seq;

  localparam int N_ITER = 12;
  localparam int ATAN [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                               41, 20, 10, 5, 3, 1, 1, 0};

  typedef struct {
    int x;
    int y;
    int z;
  } exp_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;
  exp_t sb [$];

  cordic_vec_seq_if bus ();

  cordic_vec_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp, input int tol);
    checks++;
    assert ((obs - exp) <= tol && (exp - obs) <= tol) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  function automatic int w16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return int'($signed(t));
  endfunction

  function automatic exp_t model(input int xi, input int yi);
    int   x, y, z, nx, ny;
    exp_t e;
    if (xi >= 0) begin
      x = xi; y = yi; z = 0;
    end else if (yi >= 0) begin
      x = yi; y = w16(-xi); z = 16384;
    end else begin
      x = w16(-yi); y = xi; z = -16384;
    end
    for (int i = 0; i < N_ITER; i++) begin
      if (y > 0) begin
        nx = w16(x + (y >>> i));
        ny = w16(y - (x >>> i));
        z  = w16(z + ATAN[i]);
        x = nx; y = ny;
      end else if (y < 0) begin
        nx = w16(x - (y >>> i));
        ny = w16(y + (x >>> i));
        z  = w16(z - ATAN[i]);
        x = nx; y = ny;
      end
    end
    e.x = x; e.y = y; e.z = z;
    return e;
  endfunction

  // Scoreboard: push on accept, pop/compare on output handshake.
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.in_valid && bus.in_ready)
        sb.push_back(model(int'(bus.x_in), int'(bus.y_in)));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_x", int'(bus.x_out), e.x);
          chk("sb_y", int'(bus.y_out), e.y);
          chk("sb_z", int'(bus.z_out), e.z);
        end
      end
    end
  end

  // Drive one sample; lat counts edges from the accept edge (inclusive)
  // to the edge after which out_valid is seen high.
  task automatic run_one(input int x, input int y, output int lat);
    int guard;
    @(negedge clk);
    bus.x_in     = 16'(x);
    bus.y_in     = 16'(y);
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!bus.out_valid) chk("result_timeout", 0, 1);
  endtask

  initial begin
    int lat;
    int first, prev, guard;
    logic rdy;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_in_ready",  int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy",      int'(bus.busy), 0);
    chk("rst_x",         int'(bus.x_out), 0);
    chk("rst_y",         int'(bus.y_out), 0);
    chk("rst_z",         int'(bus.z_out), 0);
    rst = 1'b0;

    // y = 0: every step holds.
    run_one(1000, 0, lat);
    chk("lat_1000_0", lat, 13);
    chk("x_1000_0", int'(bus.x_out), 1000);
    chk("y_1000_0", int'(bus.y_out), 0);
    chk("z_1000_0", int'(bus.z_out), 0);
    chk("busy_done", int'(bus.busy), 1);
    chk("in_ready_done", int'(bus.in_ready), 0);
    @(negedge clk);
    chk("out_valid_after_hs", int'(bus.out_valid), 0);
    chk("in_ready_after_hs", int'(bus.in_ready), 1);

    // (1000,1000): y reaches zero on the first step, later steps hold,
    // so the magnitude is exactly 2000 and the angle exactly pi/4.
    bus.out_ready = 1'b0;
    run_one(1000, 1000, lat);
    chk("z_pi4", int'(bus.z_out), 8192);
    chk("x_pi4", int'(bus.x_out), 2000);
    chk("y_pi4", int'(bus.y_out), 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_out_valid", int'(bus.out_valid), 1);
      chk("hold_x", int'(bus.x_out), 2000);
      chk("hold_z", int'(bus.z_out), 8192);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_out_valid", int'(bus.out_valid), 0);

    run_one(-1000, 1000, lat);
    chk("z_3pi4", int'(bus.z_out), 24576);
    chk("x_3pi4", int'(bus.x_out), 2000);
    run_one(-1000, -1000, lat);
    chk("z_m3pi4", int'(bus.z_out), -24576);
    chk("x_m3pi4", int'(bus.x_out), 2000);
    // atan(1/3) = 3356 phase units
    run_one(3000, 1000, lat);
    chk_near("z_atan_third", int'(bus.z_out), 3356, 12);

    // Continuous in_valid: accepts every 14 cycles, in_ready only in IDLE.
    @(negedge clk);
    first = -1;
    prev  = -1;
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x_in     = 16'(int'($urandom_range(0, 8000)) - 4000);
      bus.y_in     = 16'(int'($urandom_range(0, 8000)) - 4000);
      rdy = bus.in_ready;
      @(posedge clk);
      if (first >= 0)
        chk("in_ready_pattern", int'(rdy), int'(((k - first) % 14) == 0));
      if (rdy) begin
        if (first < 0) first = k;
        else chk("accept_spacing", k - prev, 14);
        prev = k;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while ((bus.busy || bus.out_valid) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_idle", int'(bus.busy), 0);

    // Reset during the 5th ROTATE cycle aborts the transaction.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x_in     = 16'(1200);
    bus.y_in     = 16'(-700);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("abort_busy", int'(bus.busy), 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready",  int'(bus.in_ready), 1);
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_busy_low",  int'(bus.busy), 0);
    chk("abort_x",         int'(bus.x_out), 0);
    chk("abort_y",         int'(bus.y_out), 0);
    chk("abort_z",         int'(bus.z_out), 0);
    run_one(1200, -700, lat);
    chk("lat_after_abort", lat, 13);

    // Random samples, bit-exact via the scoreboard.
    for (int n = 0; n < 1000; n++)
      run_one(int'($urandom_range(0, 8190)) - 4095,
              int'($urandom_range(0, 8190)) - 4095, lat);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
